// File: rtl/hx8352_pkg.sv
// Shared definitions for the HX8352 bus responder: FSM encoding, index map and RS levels.
package hx8352_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_ACTIVE = 2'd1,
        ST_RD_ACTIVE = 2'd2
    } bus_state_t;

    localparam logic [7:0] IDX_ID     = 8'h00;
    localparam logic [7:0] IDX_WIN_XS = 8'h02;
    localparam logic [7:0] IDX_WIN_XE = 8'h03;
    localparam logic [7:0] IDX_WIN_YS = 8'h04;
    localparam logic [7:0] IDX_WIN_YE = 8'h05;
    localparam logic [7:0] IDX_GRAM   = 8'h22;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

endpackage

// File: rtl/hx8352_evt_fifo.sv
// Synchronous event FIFO holding {is_data, index, value}; a push into a full FIFO with no pop is dropped.
module hx8352_evt_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              push_is_data,
    input  logic [7:0]        push_index,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    output logic              head_valid,
    output logic              head_is_data,
    output logic [7:0]        head_index,
    output logic [DATA_W-1:0] head_value,
    output logic              full,
    output logic              dropped
);

    localparam int AW = $clog2(DEPTH);

    logic              is_mem  [DEPTH];
    logic [7:0]        idx_mem [DEPTH];
    logic [DATA_W-1:0] val_mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              pop_en;
    logic              push_en;

    // Handshake: the head transfers on a cycle where head_valid and pop are both 1;
    // the head fields stay stable while head_valid=1 and pop=0.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign dropped = push && full && !pop_en;

    always_ff @(posedge clk) begin
        if (push_en) begin
            is_mem[wr_ptr[AW-1:0]]  <= push_is_data;
            idx_mem[wr_ptr[AW-1:0]] <= push_index;
            val_mem[wr_ptr[AW-1:0]] <= push_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head_valid   = !empty;
    assign head_is_data = is_mem[rd_ptr[AW-1:0]];
    assign head_index   = idx_mem[rd_ptr[AW-1:0]];
    assign head_value   = val_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hx8352_bus_responder.sv
// Panel-side HX8352 8080 bus responder: synchronizes strobes, decodes writes, queues events.
// Read-back (register file and RD_ACTIVE answers) is built only when HX8352_READBACK_EN is defined.
module hx8352_bus_responder
    import hx8352_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [7:0]        GRAM_REG    = IDX_GRAM,
    parameter logic [DATA_W-1:0] ID_VALUE    = 16'h0052,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_cs,
    input  logic              lcd_rs,
    input  logic              lcd_wr,
    input  logic              lcd_rd,
    input  logic [DATA_W-1:0] lcd_data_i,
    output logic [DATA_W-1:0] lcd_data_o,
    output logic              lcd_data_oe,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              evt_is_data,
    output logic [7:0]        evt_index,
    output logic [DATA_W-1:0] evt_value,
    output logic [31:0]       pixel_count,
    output logic              overflow,
    output logic              proto_err,
    output logic [1:0]        dbg_state
);

    logic [SYNC_STAGES-1:0] cs_sr, rs_sr, wr_sr, rd_sr;
    logic [DATA_W-1:0]      data_dl [SYNC_STAGES];
    logic                   cs_s, rs_s, wr_s, rd_s;
    logic [DATA_W-1:0]      data_s;
    bus_state_t             state;
    logic [7:0]             index;
    logic                   commit;
    logic                   fifo_full;
    logic                   fifo_drop;

    // Strobe synchronizers idle high; data rides an equal-length delay line so it lines up with wr_s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sr <= '1;
            rs_sr <= '1;
            wr_sr <= '1;
            rd_sr <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) data_dl[i] <= '0;
        end else begin
            cs_sr <= {cs_sr[SYNC_STAGES-2:0], lcd_cs};
            rs_sr <= {rs_sr[SYNC_STAGES-2:0], lcd_rs};
            wr_sr <= {wr_sr[SYNC_STAGES-2:0], lcd_wr};
            rd_sr <= {rd_sr[SYNC_STAGES-2:0], lcd_rd};
            data_dl[0] <= lcd_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) data_dl[i] <= data_dl[i-1];
        end
    end

    assign cs_s   = cs_sr[SYNC_STAGES-1];
    assign rs_s   = rs_sr[SYNC_STAGES-1];
    assign wr_s   = wr_sr[SYNC_STAGES-1];
    assign rd_s   = rd_sr[SYNC_STAGES-1];
    assign data_s = data_dl[SYNC_STAGES-1];
    assign commit = (state == ST_WR_ACTIVE) && !cs_s && wr_s;

`ifdef HX8352_READBACK_EN
    logic [DATA_W-1:0] regfile [256];
    logic [DATA_W-1:0] rd_value;
    logic [DATA_W-1:0] data_o_q;
    logic              oe_q;

    always_ff @(posedge clk) begin
        if (commit && rs_s == LCD_DATA && index != GRAM_REG) regfile[index] <= data_s;
    end

    always_comb begin
        rd_value = regfile[index];
        if (index == IDX_ID)        rd_value = ID_VALUE;
        else if (index == GRAM_REG) rd_value = '0;
    end

    assign lcd_data_o  = data_o_q;
    assign lcd_data_oe = oe_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^ID_VALUE;
    assign lcd_data_o  = '0;
    assign lcd_data_oe = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            index       <= IDX_ID;
            pixel_count <= '0;
            proto_err   <= 1'b0;
`ifdef HX8352_READBACK_EN
            oe_q        <= 1'b0;
            data_o_q    <= '0;
`endif
        end else begin
            if (!cs_s && !wr_s && !rd_s) proto_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!cs_s && !wr_s && rd_s) begin
                        state <= ST_WR_ACTIVE;
                    end
`ifdef HX8352_READBACK_EN
                    else if (!cs_s && !rd_s && wr_s) begin
                        state    <= ST_RD_ACTIVE;
                        oe_q     <= 1'b1;
                        data_o_q <= rd_value;
                    end
`endif
                end
                ST_WR_ACTIVE: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end else if (wr_s) begin
                        state <= ST_IDLE;
                        if (rs_s == LCD_CMD)        index       <= data_s[7:0];
                        else if (index == GRAM_REG) pixel_count <= pixel_count + 32'd1;
                    end
                end
                ST_RD_ACTIVE: begin
`ifdef HX8352_READBACK_EN
                    if (rd_s || cs_s) begin
                        state    <= ST_IDLE;
                        oe_q     <= 1'b0;
                        data_o_q <= '0;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           overflow <= 1'b0;
        else if (fifo_drop) overflow <= 1'b1;
    end

    assign dbg_state = state;

    hx8352_evt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (commit),
        .push_is_data (rs_s),
        .push_index   (index),
        .push_value   (data_s),
        .pop          (evt_ready),
        .head_valid   (evt_valid),
        .head_is_data (evt_is_data),
        .head_index   (evt_index),
        .head_value   (evt_value),
        .full         (fifo_full),
        .dropped      (fifo_drop)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_hx8352_bus_responder.sv
// Directed bench for hx8352_bus_responder; read-back checks follow HX8352_READBACK_EN.
module tb_hx8352_bus_responder;
    import hx8352_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd;
    logic [15:0] lcd_data_i;
    logic [15:0] lcd_data_o;
    logic        lcd_data_oe;
    logic        evt_valid, evt_ready, evt_is_data;
    logic [7:0]  evt_index;
    logic [15:0] evt_value;
    logic [31:0] pixel_count;
    logic        overflow, proto_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    hx8352_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_cs      (lcd_cs),
        .lcd_rs      (lcd_rs),
        .lcd_wr      (lcd_wr),
        .lcd_rd      (lcd_rd),
        .lcd_data_i  (lcd_data_i),
        .lcd_data_o  (lcd_data_o),
        .lcd_data_oe (lcd_data_oe),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_is_data (evt_is_data),
        .evt_index   (evt_index),
        .evt_value   (evt_value),
        .pixel_count (pixel_count),
        .overflow    (overflow),
        .proto_err   (proto_err),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic bus_write(input logic rs, input logic [15:0] value, input logic [7:0] exp_idx);
        @(negedge clk);
        lcd_cs = 1'b0; lcd_rs = rs; lcd_data_i = value;
        cycles(1);
        lcd_wr = 1'b0;
        cycles(4);
        lcd_wr = 1'b1;
        cycles(4);
        lcd_cs = 1'b1;
        cycles(2);
        exp_q.push_back({rs, exp_idx, value});
    endtask

    task automatic drain_one();
        logic [24:0] exp;
        int waited = 0;
        exp = exp_q.pop_front();
        while (!evt_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("evt_valid", {31'd0, evt_valid}, 32'd1);
        chk("evt_payload", {7'd0, evt_is_data, evt_index, evt_value}, {7'd0, exp});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) drain_one();
        chk("evt_empty", {31'd0, evt_valid}, 32'd0);
    endtask

    task automatic rd_pulse(input logic [15:0] exp_val);
        int lat = 0;
        @(negedge clk);
        lcd_cs = 1'b0; lcd_rd = 1'b0;
`ifdef HX8352_READBACK_EN
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (lcd_data_oe) begin lat = i; break; end
        end
        chk("rd_latency", lat, SYNC + 1);
        chk("rd_data", {16'd0, lcd_data_o}, {16'd0, exp_val});
        lcd_rd = 1'b1;
        cycles(4);
        chk("rd_oe_off", {31'd0, lcd_data_oe}, 32'd0);
`else
        cycles(6);
        chk("rd_oe_tied", {31'd0, lcd_data_oe}, 32'd0);
        chk("rd_data_tied", {16'd0, lcd_data_o}, {16'd0, 16'h0000 & exp_val});
        lcd_rd = 1'b1;
        cycles(2);
        lat = 0;
`endif
        lcd_cs = 1'b1;
        cycles(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk({tag, "_evt_valid"}, {31'd0, evt_valid}, 32'd0);
        chk({tag, "_oe"}, {31'd0, lcd_data_oe}, 32'd0);
        chk({tag, "_data_o"}, {16'd0, lcd_data_o}, 32'd0);
        chk({tag, "_pixels"}, pixel_count, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_proto"}, {31'd0, proto_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        lcd_cs = 1'b1; lcd_rs = 1'b1; lcd_wr = 1'b1; lcd_rd = 1'b1;
        lcd_data_i = 16'h0000; evt_ready = 1'b0;
        cycles(3);
        chk_reset_outputs("reset");
        rst = 1'b1;
        cycles(2);

        // GRAM index then three pixels
        bus_write(LCD_CMD,  16'h0022, 8'h00);
        bus_write(LCD_DATA, 16'hF800, 8'h22);
        bus_write(LCD_DATA, 16'hF800, 8'h22);
        bus_write(LCD_DATA, 16'hF800, 8'h22);
        chk("pixels_3", pixel_count, 32'd3);
        chk("no_overflow_4", {31'd0, overflow}, 32'd0);
        drain_all();

        // window register write and read-back
        bus_write(LCD_CMD,  16'h0005, 8'h22);
        bus_write(LCD_DATA, 16'h00EF, 8'h05);
        drain_all();
        rd_pulse(16'h00EF);
        chk("pixels_still_3", pixel_count, 32'd3);

        // ID register read
        bus_write(LCD_CMD, 16'h0000, 8'h05);
        drain_all();
        rd_pulse(16'h0052);

        // five writes with consumer stalled: fifth is dropped
        bus_write(LCD_DATA, 16'h1111, 8'h00);
        bus_write(LCD_DATA, 16'h2222, 8'h00);
        bus_write(LCD_DATA, 16'h3333, 8'h00);
        bus_write(LCD_DATA, 16'h4444, 8'h00);
        bus_write(LCD_DATA, 16'h5555, 8'h00);
        void'(exp_q.pop_back());
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        chk("fifo_holds", {31'd0, evt_valid}, 32'd1);
        drain_all();

        // CS rises while WR still low: write aborted
        @(negedge clk);
        lcd_cs = 1'b0; lcd_rs = LCD_CMD; lcd_data_i = 16'h0033;
        cycles(1);
        lcd_wr = 1'b0;
        cycles(4);
        chk("abort_in_wr", {30'd0, dbg_state}, {30'd0, ST_WR_ACTIVE});
        lcd_cs = 1'b1;
        cycles(4);
        lcd_wr = 1'b1;
        cycles(4);
        chk("abort_no_evt", {31'd0, evt_valid}, 32'd0);
        chk("abort_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("proto_clear", {31'd0, proto_err}, 32'd0);
        bus_write(LCD_DATA, 16'h0ABC, 8'h00);
        drain_all();

        // WR and RD both low under CS
        @(negedge clk);
        lcd_cs = 1'b0; lcd_wr = 1'b0; lcd_rd = 1'b0;
        cycles(4);
        lcd_wr = 1'b1; lcd_rd = 1'b1;
        cycles(1);
        lcd_cs = 1'b1;
        cycles(4);
        chk("proto_set", {31'd0, proto_err}, 32'd1);
        chk("proto_no_evt", {31'd0, evt_valid}, 32'd0);

        // reset asserted in the middle of a write
        @(negedge clk);
        lcd_cs = 1'b0; lcd_rs = LCD_CMD; lcd_data_i = 16'h0044;
        cycles(1);
        lcd_wr = 1'b0;
        cycles(4);
        chk("mid_in_wr", {30'd0, dbg_state}, {30'd0, ST_WR_ACTIVE});
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        lcd_wr = 1'b1; lcd_cs = 1'b1;
        cycles(3);
        rst = 1'b1;
        cycles(2);
        bus_write(LCD_CMD,  16'h0002, 8'h00);
        bus_write(LCD_DATA, 16'h1234, 8'h02);
        drain_all();
        chk("post_reset_pixels", pixel_count, 32'd0);
        chk("post_reset_overflow", {31'd0, overflow}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hx8352_bus_responder.md
Name: hx8352_bus_responder

Overview:
- Target-side model of the HX8352 8080-style parallel LCD bus: the panel end of the bus driven by hx8352_controller.
- Samples CS/RS/WR/RD asynchronously, decodes index (command) and data writes, and keeps an index register plus a 256x16 register file.
- Answers RD strobes with register contents.
- Queues every decoded write as an event in a small FIFO so a checker or debug UART can consume the traffic.
- Synthesizable; also used as a bus partner in system_tb.

Parameters:
- DATA_W, 16, LCD data bus width
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
- GRAM_REG, 8'h22, index whose data writes are pixel stream (not stored)
- ID_VALUE, 16'h0052, value returned when reading index 8'h00
- SYNC_STAGES, 2, synchronizer depth on bus strobes (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- lcd_cs  in  1  chip select, active low
- lcd_rs  in  1  0 = index/command, 1 = data
- lcd_wr  in  1  write strobe, active low, data latched on rising edge
- lcd_rd  in  1  read strobe, active low
- lcd_data_i  in  DATA_W  bus data from controller
- lcd_data_o  out  DATA_W  read-back data
- lcd_data_oe  out  1  tri-state enable for lcd_data_o
- evt_valid  out  1  event FIFO head valid
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_is_data  out  1  head: 0 index write, 1 data write
- evt_index  out  8  head: index register value at time of write
- evt_value  out  DATA_W  head: bus value written
- pixel_count  out  32  number of GRAM_REG data writes since reset
- overflow  out  1  sticky: event dropped, FIFO full
- proto_err  out  1  sticky: WR and RD both low with CS low

Behaviour:
- Reset (rst=0, async): index=8'h00, regfile contents undefined (not reset), FIFO empty, evt_valid=0, lcd_data_oe=0, lcd_data_o=0, pixel_count=0, overflow=0, proto_err=0, FSM=IDLE. Synchronizer flops reset to 1 (bus idle).
- lcd_cs, lcd_rs, lcd_wr, lcd_rd pass through SYNC_STAGES flops. lcd_data_i passes through a matching SYNC_STAGES-deep delay line so data aligns with the synchronized WR edge.
- FSM states: IDLE, WR_ACTIVE, RD_ACTIVE.
- IDLE -> WR_ACTIVE: synced cs=0 and wr=0 and rd=1.
- IDLE -> RD_ACTIVE: synced cs=0 and rd=0 and wr=1.
- Both wr and rd low with cs low: set proto_err, stay IDLE.
- WR_ACTIVE, synced wr rises with cs=0: commit using the aligned data sample, then go to IDLE.
  - rs=0: index <= data[7:0]; push event {0, old index, data}.
  - rs=1, index==GRAM_REG: pixel_count += 1 (wraps at 2^32); push event.
  - rs=1, other index: regfile[index] <= data; push event. Index does not auto-increment.
- WR_ACTIVE, synced cs rises before wr rises: abort, no commit, go to IDLE.
- RD_ACTIVE: lcd_data_oe=1 on the first cycle in the state. lcd_data_o = ID_VALUE if index==0, else regfile[index] (0 for GRAM_REG).
- Leave RD_ACTIVE when synced rd=1 or cs=1: lcd_data_oe=0 the same cycle, go to IDLE. Read-back latency is SYNC_STAGES+1 clocks after RD falls.
- FIFO: push and pop in the same cycle is allowed, including when full (pop frees the slot, so no overflow). A push into a full FIFO without a pop drops the event and sets overflow. Head outputs are stable while evt_valid=1 and evt_ready=0.
- Reset mid-transaction: everything returns to reset values immediately; the bus write in flight is lost.

Optional Feature:
- Macro: HX8352_READBACK_EN
- Defined: regfile, RD_ACTIVE state and read-back behave as above.
- Undefined: no regfile is built. lcd_data_oe is tied 0 and lcd_data_o tied 0. RD strobes are ignored apart from the proto_err check. Index, pixel_count and events are unaffected.

Decomposition:
- Shared package hx8352_pkg holds: FSM state encoding; index constants (8'h00 ID, 8'h22 GRAM, 8'h02..8'h05 window registers); LCD_CMD=1'b0, LCD_DATA=1'b1.
- One sub-module: hx8352_evt_fifo, a synchronous FIFO with a {is_data,index,value} payload, a full/empty flag and a drop-on-full push port.

Test Plan:
- Index write 16'h0022 then 3 data writes 16'hF800 -> 4 events ({0,00,0022},{1,22,F800}x3), pixel_count=3, regfile unchanged.
- Index 8'h05, data 16'h00EF, then RD pulse -> lcd_data_oe high within SYNC_STAGES+1 clocks of RD fall, lcd_data_o=16'h00EF, oe low once RD is high.
- Index 8'h00, RD pulse -> lcd_data_o=16'h0052.
- evt_ready=0, 5 writes with FIFO_DEPTH=4 -> 4 events retained, overflow=1; drain -> events 1-4 in order.
- WR low, then CS high before WR high -> no event, index unchanged. Then WR and RD both low with CS low -> proto_err=1.
- rst pulled low during WR_ACTIVE -> all outputs at reset values; after release, the next write is decoded normally.
